// File: rtl/norm_pkg.sv
// norm_pkg: constants and helpers shared by the normaliser pipeline.
//   lz_width     : width of a leading-zero count for a given data width
//   max_width    : larger of two widths (for the shift/compare datapath)
//   exp_all_ones : all-ones value of a biased exponent of a given width
//   FLAG_*       : bit positions in the registered flag vector
package norm_pkg;

    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_DENORM = 1;
    localparam int FLAG_OVF    = 2;
    localparam int FLAG_W      = 3;

    function automatic int lz_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned exp_all_ones(input int exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

endpackage

// File: rtl/norm_pipe_if.sv
// norm_pipe_if: valid/ready bus for the mantissa normaliser.
//   in_valid/in_ready/in_mant/in_exp        : upstream beat
//   out_valid/out_ready/out_mant/out_exp    : normalised result
//   out_zero/out_denorm/out_ovf             : result flags
//   out_sticky                              : only when NORM_STICKY_EN is defined
// modport master: the producer/consumer side; modport slave: the normaliser.
interface norm_pipe_if #(
    parameter int MANT_W = 8,
    parameter int EXP_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_denorm;
    logic              out_ovf;
`ifdef NORM_STICKY_EN
    logic              out_sticky;
`endif

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp,
        input  out_zero, out_denorm, out_ovf
`ifdef NORM_STICKY_EN
        , input out_sticky
`endif
    );

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp,
        output out_zero, out_denorm, out_ovf
`ifdef NORM_STICKY_EN
        , output out_sticky
`endif
    );

endinterface

// File: rtl/leading_zero_counter.sv
// leading_zero_counter: counts zeros above the most significant set bit.
//   data  : input word (DATA_W bits)
//   count : number of leading zeros; DATA_W when data is zero
module leading_zero_counter #(
    parameter int DATA_W = 8,
    parameter int LZ_W   = $clog2(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] data,
    output logic [LZ_W-1:0]   count
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = LZ_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) begin
                count = LZ_W'(DATA_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/norm_pipe.sv
// norm_pipe: two-stage pipelined mantissa normaliser with valid/ready flow.
//   clk : clock
//   rst : synchronous reset, active-high
//   bus : norm_pipe_if.slave (input beat, result, flags)
// Stage 1 registers the beat and its leading-zero count; stage 2 registers
// the shifted mantissa, adjusted exponent and flags.
// Optional: NORM_STICKY_EN adds out_sticky, the bit dropped by the carry shift.
module norm_pipe
    import norm_pkg::*;
#(
    parameter int MANT_W = 8,
    parameter int EXP_W  = 5
) (
    input logic       clk,
    input logic       rst,
    norm_pipe_if.slave bus
);

    localparam int LZ_W  = lz_width(MANT_W);
    localparam int CMP_W = max_width(EXP_W, LZ_W);
    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_all_ones(EXP_W));
    localparam logic [LZ_W-1:0]  LZ_ZERO  = LZ_W'(MANT_W);
    localparam logic [EXP_W:0]   EXP_ONE  = (EXP_W+1)'(1);

    logic              adv1;
    logic              adv2;
    logic [LZ_W-1:0]   lz_in;

    logic              s1_valid;
    logic [MANT_W-1:0] s1_mant;
    logic [EXP_W-1:0]  s1_exp;
    logic [LZ_W-1:0]   s1_lz;

    logic              out_valid_q;
    logic [MANT_W-1:0] out_mant_q;
    logic [EXP_W-1:0]  out_exp_q;
    logic [FLAG_W-1:0] flags_q;

    logic [CMP_W-1:0]  exp_ext;
    logic [CMP_W-1:0]  want;
    logic [CMP_W-1:0]  shift;
    logic [EXP_W:0]    exp_inc;
    logic [MANT_W-1:0] nxt_mant;
    logic [EXP_W-1:0]  nxt_exp;
    logic [FLAG_W-1:0] nxt_flags;
`ifdef NORM_STICKY_EN
    logic              nxt_sticky;
    logic              sticky_q;
`endif

    assign adv2        = !out_valid_q || bus.out_ready;
    assign adv1        = !s1_valid || adv2;
    assign bus.in_ready = adv1;

    leading_zero_counter #(
        .DATA_W (MANT_W),
        .LZ_W   (LZ_W)
    ) u_lzc (
        .data  (bus.in_mant),
        .count (lz_in)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_lz    <= '0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_mant <= bus.in_mant;
                s1_exp  <= bus.in_exp;
                s1_lz   <= lz_in;
            end
        end
    end

    // Carry is checked first (lz is 0 there, so want would underflow);
    // a zero mantissa beats the all-ones exponent pass-through.
    always_comb begin
        exp_ext   = CMP_W'(s1_exp);
        want      = CMP_W'(s1_lz) - CMP_W'(1);
        shift     = (want < exp_ext) ? want : exp_ext;
        exp_inc   = {1'b0, s1_exp} + EXP_ONE;
        nxt_mant  = s1_mant;
        nxt_exp   = s1_exp;
        nxt_flags = '0;
`ifdef NORM_STICKY_EN
        nxt_sticky = 1'b0;
`endif
        if (s1_mant[MANT_W-1]) begin
`ifdef NORM_STICKY_EN
            nxt_sticky = s1_mant[0];
`endif
            // Saturate also covers an all-ones input exponent with carry.
            if (exp_inc >= {1'b0, EXP_ONES}) begin
                nxt_mant            = '0;
                nxt_exp             = EXP_ONES;
                nxt_flags[FLAG_OVF] = 1'b1;
            end else begin
                nxt_mant = s1_mant >> 1;
                nxt_exp  = exp_inc[EXP_W-1:0];
            end
        end else if (s1_lz == LZ_ZERO) begin
            nxt_mant             = '0;
            nxt_exp              = '0;
            nxt_flags[FLAG_ZERO] = 1'b1;
        end else if (s1_exp == EXP_ONES) begin
            nxt_flags[FLAG_OVF] = 1'b1;
        end else begin
            // shift <= exp, so the exponent cannot wrap and the cast is lossless.
            nxt_mant               = s1_mant << shift;
            nxt_exp                = s1_exp - EXP_W'(shift);
            nxt_flags[FLAG_DENORM] = (shift < want);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
            flags_q     <= '0;
`ifdef NORM_STICKY_EN
            sticky_q    <= 1'b0;
`endif
        end else if (adv2) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_mant_q <= nxt_mant;
                out_exp_q  <= nxt_exp;
                flags_q    <= nxt_flags;
`ifdef NORM_STICKY_EN
                sticky_q   <= nxt_sticky;
`endif
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_mant   = out_mant_q;
    assign bus.out_exp    = out_exp_q;
    assign bus.out_zero   = flags_q[FLAG_ZERO];
    assign bus.out_denorm = flags_q[FLAG_DENORM];
    assign bus.out_ovf    = flags_q[FLAG_OVF];
`ifdef NORM_STICKY_EN
    assign bus.out_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_norm_pipe.sv
// tb_norm_pipe: self-checking bench for norm_pipe (MANT_W=8, EXP_W=5).
// Vector table of {input, expected result}; expected records are queued when
// a beat is accepted and compared when a result is taken.
// Honours NORM_STICKY_EN for the out_sticky comparison.
module tb_norm_pipe;

    localparam int MW = 8;
    localparam int EW = 5;
    localparam int NV = 12;

    typedef struct {
        logic [MW-1:0] mant;
        logic [EW-1:0] exp;
        logic [MW-1:0] e_mant;
        logic [EW-1:0] e_exp;
        logic          e_zero;
        logic          e_denorm;
        logic          e_ovf;
        logic          e_sticky;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    norm_pipe_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

    norm_pipe #(.MANT_W(MW), .EXP_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t vecs[NV];
    vec_t sb[$];
    int   cur_idx   = 0;
    int   errors    = 0;
    int   checks    = 0;
    int   out_count = 0;

    function automatic vec_t mk(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                input logic [MW-1:0] em, input logic [EW-1:0] ee,
                                input logic z, input logic d, input logic o, input logic s);
        vec_t v;
        v.mant = m; v.exp = e; v.e_mant = em; v.e_exp = ee;
        v.e_zero = z; v.e_denorm = d; v.e_ovf = o; v.e_sticky = s;
        return v;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic monitor();
        vec_t        e;
        logic [31:0] act;
        logic [31:0] req;
        if (rst) return;
        if (bus.out_valid && bus.out_ready) begin
            out_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_beat: got mant=%b exp=%0d, required no output",
                         bus.out_mant, bus.out_exp);
            end else begin
                e = sb.pop_front();
`ifdef NORM_STICKY_EN
                act = 32'({bus.out_mant, bus.out_exp, bus.out_zero, bus.out_denorm,
                           bus.out_ovf, bus.out_sticky});
                req = 32'({e.e_mant, e.e_exp, e.e_zero, e.e_denorm, e.e_ovf, e.e_sticky});
`else
                act = 32'({bus.out_mant, bus.out_exp, bus.out_zero, bus.out_denorm,
                           bus.out_ovf});
                req = 32'({e.e_mant, e.e_exp, e.e_zero, e.e_denorm, e.e_ovf});
`endif
                check1("result", act, req);
            end
        end
        if (bus.in_valid && bus.in_ready) sb.push_back(vecs[cur_idx]);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
    endtask

    task automatic drive_idle();
        bus.in_valid = 1'b0;
        bus.in_mant  = '0;
        bus.in_exp   = '0;
    endtask

    task automatic drive_vec(input int i);
        cur_idx      = i;
        bus.in_valid = 1'b1;
        bus.in_mant  = vecs[i].mant;
        bus.in_exp   = vecs[i].exp;
    endtask

    task automatic run_stream(input int nbeats, input bit rand_ready, input bit rand_valid,
                              input bit in_order);
        int sent  = 0;
        int guard = 0;
        while ((sent < nbeats || sb.size() != 0) && guard < 5000) begin
            @(posedge clk); #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < nbeats && (!rand_valid || $urandom_range(0, 3) != 0))
                drive_vec(in_order ? (sent % NV) : int'($urandom_range(0, NV - 1)));
            else
                drive_idle();
            step();
            if (bus.in_valid && bus.in_ready) sent++;
            guard++;
        end
        @(posedge clk); #1;
        drive_idle();
        if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got sent=%0d pending=%0d, required all drained",
                     sent, sb.size());
        end
    endtask

    initial begin
        int          acc;
        logic [31:0] snap;
        int          cnt_before;

        vecs[0]  = mk(8'b00010110, 5'd10, 8'b01011000, 5'd8,  0, 0, 0, 0);
        vecs[1]  = mk(8'b10000011, 5'd10, 8'b01000001, 5'd11, 0, 0, 0, 1);
        vecs[2]  = mk(8'b00000011, 5'd2,  8'b00001100, 5'd0,  0, 1, 0, 0);
        vecs[3]  = mk(8'b00000000, 5'd7,  8'b00000000, 5'd0,  1, 0, 0, 0);
        vecs[4]  = mk(8'b11000000, 5'd30, 8'b00000000, 5'd31, 0, 0, 1, 0);
        vecs[5]  = mk(8'b01000000, 5'd5,  8'b01000000, 5'd5,  0, 0, 0, 0);
        vecs[6]  = mk(8'b00000001, 5'd20, 8'b01000000, 5'd14, 0, 0, 0, 0);
        vecs[7]  = mk(8'b00000001, 5'd0,  8'b00000001, 5'd0,  0, 1, 0, 0);
        vecs[8]  = mk(8'b00100000, 5'd1,  8'b01000000, 5'd0,  0, 0, 0, 0);
        vecs[9]  = mk(8'b10000000, 5'd0,  8'b01000000, 5'd1,  0, 0, 0, 0);
        vecs[10] = mk(8'b11111111, 5'd29, 8'b01111111, 5'd30, 0, 0, 0, 1);
        vecs[11] = mk(8'b00000000, 5'd0,  8'b00000000, 5'd0,  1, 0, 0, 0);

        drive_idle();
        bus.out_ready = 1'b0;
        rst = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check1("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check1("rst_outputs", 32'({bus.out_mant, bus.out_exp, bus.out_zero,
                                   bus.out_denorm, bus.out_ovf}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two-cycle latency of a single beat
        bus.out_ready = 1'b1;
        drive_vec(0);
        step();
        check1("lat_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        drive_idle();
        step();
        check1("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        step();
        check1("lat_cycle2_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        step();

        // Whole table at full throughput
        run_stream(NV, 1'b0, 1'b0, 1'b1);

        // Backpressure: 4 beats back-to-back, consumer stalled for cycles 0..3
        acc  = 0;
        snap = '0;
        for (int cyc = 0; cyc < 40 && !(acc == 4 && sb.size() == 0); cyc++) begin
            @(posedge clk); #1;
            bus.out_ready = (cyc >= 4);
            if (acc < 4) drive_vec(acc + 1);
            else         drive_idle();
            step();
            if (cyc == 2) begin
                check1("bp_accepted", 32'(acc), 32'd2);
                check1("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                check1("bp_out_valid", 32'(bus.out_valid), 32'd1);
                snap = 32'({bus.out_mant, bus.out_exp, bus.out_zero, bus.out_denorm,
                            bus.out_ovf});
            end
            if (cyc == 3) begin
                check1("bp_hold_stable", 32'({bus.out_mant, bus.out_exp, bus.out_zero,
                                              bus.out_denorm, bus.out_ovf}), snap);
                check1("bp_still_full", 32'(bus.in_ready), 32'd0);
            end
            if (bus.in_valid && bus.in_ready) acc++;
        end
        check1("bp_all_accepted", 32'(acc), 32'd4);
        check1("bp_drained", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        drive_idle();
        bus.out_ready = 1'b1;

        // Random valid/ready traffic
        run_stream(150, 1'b1, 1'b1, 1'b0);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        drive_vec(6);
        step();
        @(posedge clk); #1;
        drive_vec(7);
        step();
        @(posedge clk); #1;
        drive_idle();
        step();
        check1("full_out_valid", 32'(bus.out_valid), 32'd1);
        check1("full_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        step();
        check1("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check1("midrst_outputs", 32'({bus.out_mant, bus.out_exp, bus.out_zero,
                                      bus.out_denorm, bus.out_ovf}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cnt_before = out_count;
        repeat (6) begin
            @(posedge clk); #1;
            step();
        end
        check1("no_stale_beat", 32'(out_count - cnt_before), 32'd0);
        check1("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
